// File: rtl/mips_pkg.sv
// Shared types and constants for the PC/fetch sequencer and its next-PC datapath.
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  localparam logic [31:0] PC_INCR          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
module next_pc_calc (
  input  logic [31:0] pc_plus4,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  output logic [31:0] next_pc
);

  logic [31:0] branch_off;
  logic [31:0] jump_target;

  // Branch offset is in words; sign-extend then scale to bytes.
  assign branch_off  = {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target = {pc_plus4[31:28], jump_index, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (pc_src) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Non-speculative PC owner and single-outstanding fetch issuer.
// Optional PC_BRANCH_STATS_EN adds saturating taken-branch and jump counters.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        resolve_valid,
  input  logic        pc_src,
  input  logic        jump,
  input  logic [15:0] branch_imm,
`ifdef PC_BRANCH_STATS_EN
  input  logic [25:0] jump_index,
  output logic [15:0] br_taken_cnt,
  output logic [15:0] jump_cnt
`else
  input  logic [25:0] jump_index
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] next_pc;
  logic        resolve_fire;

  assign pc         = pc_q;
  assign pc_plus4   = pc_q + PC_INCR;
  assign fetch_addr = pc_q;

  next_pc_calc u_next_pc (
    .pc_plus4   (pc_plus4),
    .pc_src     (pc_src),
    .jump       (jump),
    .branch_imm (branch_imm),
    .jump_index (jump_index),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_valid  = 1'b0;
    resolve_fire = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!stall) state_d = S_FETCH;
      end
      // A raised request stays up until accepted, regardless of stall.
      S_FETCH: begin
        fetch_valid = 1'b1;
        if (fetch_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (resolve_valid) begin
          resolve_fire = 1'b1;
          pc_d         = next_pc;
          state_d      = stall ? S_IDLE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef PC_BRANCH_STATS_EN
  logic [15:0] br_cnt_q, br_cnt_d;
  logic [15:0] jmp_cnt_q, jmp_cnt_d;

  assign br_taken_cnt = br_cnt_q;
  assign jump_cnt     = jmp_cnt_q;

  always_comb begin
    br_cnt_d  = br_cnt_q;
    jmp_cnt_d = jmp_cnt_q;
    if (resolve_fire) begin
      if (jump) begin
        if (jmp_cnt_q != 16'hFFFF) jmp_cnt_d = jmp_cnt_q + 16'd1;
      end else if (pc_src) begin
        if (br_cnt_q != 16'hFFFF) br_cnt_d = br_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_cnt_q  <= 16'd0;
      jmp_cnt_q <= 16'd0;
    end else begin
      br_cnt_q  <= br_cnt_d;
      jmp_cnt_q <= jmp_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized self-checking bench for pc_sequencer against an instruction-level PC model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, fetch_ready, resolve_valid, pc_src, jump;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic        fetch_valid;
  logic [31:0] fetch_addr, pc, pc_plus4;
`ifdef PC_BRANCH_STATS_EN
  logic [15:0] br_taken_cnt, jump_cnt;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mpc;
  int          m_br = 0;
  int          m_jp = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_addr    (fetch_addr),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .resolve_valid (resolve_valid),
    .pc_src        (pc_src),
    .jump          (jump),
    .branch_imm    (branch_imm),
`ifdef PC_BRANCH_STATS_EN
    .jump_index    (jump_index),
    .br_taken_cnt  (br_taken_cnt),
    .jump_cnt      (jump_cnt)
`else
    .jump_index    (jump_index)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rules in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] p, input bit j, input bit b,
                                             input logic [15:0] imm, input logic [25:0] idx);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    off = $signed(imm);
    if (j) return (seq & 32'hF000_0000) | ({6'd0, idx} << 2);
    if (b) return seq + 32'(off * 4);
    return seq;
  endfunction

  // One instruction: fetch handshake, resolve, optional post-resolve stall.
  task automatic do_instr(input bit j, input bit b, input logic [15:0] imm,
                          input logic [25:0] idx, input bit rnd, input bit quiet);
    int          nw, nx, ns;
    bit          s;
    logic [31:0] exp;
    nw = rnd ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i < nw; i++) begin
      check("fv_hold", fetch_valid, 1);
      check("fa_hold", fetch_addr, mpc);
      fetch_ready   = 1'b0;
      stall         = 1'($urandom_range(0, 1));
      resolve_valid = 1'($urandom_range(0, 1));
      jump          = 1'($urandom_range(0, 1));
      pc_src        = 1'($urandom_range(0, 1));
      branch_imm    = 16'($urandom);
      jump_index    = 26'($urandom);
      step();
      check("pc_stray", pc, mpc);
    end
    check("fv_req", fetch_valid, 1);
    check("fa_req", fetch_addr, mpc);
    fetch_ready   = 1'b1;
    resolve_valid = 1'b0;
    stall         = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    step();
    fetch_ready = 1'b0;
    stall       = 1'b0;
    nx = rnd ? int'($urandom_range(0, 2)) : 0;
    for (int i = 0; i < nx; i++) begin
      check("fv_wait", fetch_valid, 0);
      step();
      check("pc_wait", pc, mpc);
    end
    check("fv_wait", fetch_valid, 0);
    s             = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
    resolve_valid = 1'b1;
    jump          = j;
    pc_src        = b;
    branch_imm    = imm;
    jump_index    = idx;
    stall         = s;
    exp           = model_next(mpc, j, b, imm, idx);
    step();
    resolve_valid = 1'b0;
    if (j) m_jp++;
    else if (b) m_br++;
    if (m_jp > 65535) m_jp = 65535;
    if (m_br > 65535) m_br = 65535;
    check("pc", pc, exp);
    check("pc_plus4", pc_plus4, exp + 32'd4);
    check("fv_after", fetch_valid, {31'd0, !s});
    if (!s) check("fa_after", fetch_addr, exp);
    if (!quiet)
      $display("instr: pc %h j=%0d b=%0d imm=%h idx=%h stall=%0d -> pc %h",
               mpc, j, b, imm, idx, s, exp);
    mpc = exp;
    if (s) begin
      ns = int'($urandom_range(0, 3));
      for (int i = 0; i < ns; i++) begin
        stall = 1'b1;
        step();
        check("fv_idle", fetch_valid, 0);
      end
      stall = 1'b0;
      step();
      check("fv_resume", fetch_valid, 1);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; fetch_ready = 1'b0; resolve_valid = 1'b0;
    pc_src = 1'b0; jump = 1'b0; branch_imm = '0; jump_index = '0;
    repeat (3) step();
    check("rst_fv", fetch_valid, 0);
    check("rst_pc", pc, 32'h0000_0000);
    check("rst_pc4", pc_plus4, 32'h0000_0004);
`ifdef PC_BRANCH_STATS_EN
    check("rst_br", br_taken_cnt, 0);
    check("rst_jp", jump_cnt, 0);
`endif
    reset = 1'b0;
    mpc   = 32'h0000_0000;
    step();
    check("first_fa", fetch_addr, 32'h0000_0000);

    do_instr(0, 0, 16'h0000, 26'h0, 0, 0);
    check("seq_4", pc, 32'h0000_0004);
    do_instr(0, 1, 16'hFFFD, 26'h0, 0, 0);
    check("to_top", pc, 32'hFFFF_FFFC);
    do_instr(0, 0, 16'h0000, 26'h0, 0, 0);
    check("wrap", pc, 32'h0000_0000);
    do_instr(1, 0, 16'h0000, 26'h10, 0, 0);
    check("jmp_40", pc, 32'h0000_0040);
    do_instr(0, 1, 16'hFFFE, 26'h0, 0, 0);
    check("br_back", pc, 32'h0000_003C);
    do_instr(1, 0, 16'h0000, 26'h10, 0, 0);
    do_instr(0, 1, 16'h0003, 26'h0, 0, 0);
    check("br_fwd", pc, 32'h0000_0050);
    do_instr(1, 0, 16'h0000, 26'h0, 0, 0);

    // Walk up to 0x1000_0000 with maximal forward branches.
    for (int i = 0; i < 2048; i++) do_instr(0, 1, 16'h7FFF, 26'h0, 0, 1);
    check("ramp", pc, 32'h1000_0000);
    do_instr(0, 0, 16'h0000, 26'h0, 0, 0);
    do_instr(0, 0, 16'h0000, 26'h0, 0, 0);
    do_instr(1, 1, 16'h1234, 26'h000_0100, 0, 0);
    check("jump_prio", pc, 32'h1000_0400);

    for (int i = 0; i < 300; i++)
      do_instr($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
               16'($urandom), 26'($urandom), 1, 0);

`ifdef PC_BRANCH_STATS_EN
    check("br_cnt", br_taken_cnt, 32'(m_br));
    check("jp_cnt", jump_cnt, 32'(m_jp));
`endif

    // Reset while a request is pending in S_FETCH.
    check("pre_rst_fv", fetch_valid, 1);
    fetch_ready = 1'b0;
    reset       = 1'b1;
    step();
    check("rst2_fv", fetch_valid, 0);
    check("rst2_pc", pc, 32'h0000_0000);
`ifdef PC_BRANCH_STATS_EN
    check("rst2_br", br_taken_cnt, 0);
    check("rst2_jp", jump_cnt, 0);
`endif
    reset = 1'b0;
    step();
    check("rst2_resume", fetch_valid, 1);
    check("rst2_fa", fetch_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
